// File: rtl/router_input_fifo_pkg.sv
// Shared constants for the router input-port FIFO: default flit width and depth.
package router_input_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_PTR_W      = $clog2(DEFAULT_DEPTH);

endpackage : router_input_fifo_pkg

// File: rtl/router_input_fifo_mem.sv
// Flit storage for the input FIFO: register array with synchronous write and
// asynchronous read. The contents are deliberately left out of reset.
module router_input_fifo_mem
  import router_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : router_input_fifo_mem

// File: rtl/router_input_fifo.sv
// Router input port: first-word-fall-through FIFO capturing upstream flits,
// returning one credit per dequeue and flagging sticky overflow/underflow.
module router_input_fifo
  import router_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  validin,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count,
  output logic                  credit_out,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  r_credit;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [DATA_WIDTH-1:0] w_dataout;

  assign w_empty = (r_count == {(PTR_W+1){1'b0}});
  assign w_full  = (r_count == CNT_FULL);
  assign w_rd_ok = rd_en && !w_empty;
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign w_wr_ok = validin && (!w_full || w_rd_ok);

  router_input_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (datain),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_credit <= w_rd_ok;
      if (validin && w_full && !rd_en) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  always_comb begin
    w_dataout = {DATA_WIDTH{1'b0}};
    if (!w_empty) begin
      w_dataout = w_mem_rdata;
    end else begin
      w_dataout = {DATA_WIDTH{1'b0}};
    end
  end

  assign dataout       = w_dataout;
  assign empty         = w_empty;
  assign full          = w_full;
  assign count         = r_count;
  assign credit_out    = r_credit;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule : router_input_fifo

// File: tb/tb_router_input_fifo.sv
// Self-checking bench for router_input_fifo: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_router_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] datain;
  logic          validin;
  logic          rd_en;
  logic [DW-1:0] dataout;
  logic          empty;
  logic          full;
  logic [PW:0]   count;
  logic          credit_out;
  logic          overflow_err;
  logic          underflow_err;

  int n_checks;
  int n_errors;
  int n_cred;

  logic [DW-1:0] m_q[$];
  bit            m_ovf;
  bit            m_unf;
  bit            m_credit;

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .datain        (datain),
    .validin       (validin),
    .rd_en         (rd_en),
    .dataout       (dataout),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .credit_out    (credit_out),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ctx);
    logic [31:0] exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : 32'h0;
    check_eq({ctx, ".empty"},  32'(empty),         32'(m_q.size() == 0));
    check_eq({ctx, ".full"},   32'(full),          32'(m_q.size() == DEPTH));
    check_eq({ctx, ".count"},  32'(count),         32'(m_q.size()));
    check_eq({ctx, ".data"},   dataout,            exp_head);
    check_eq({ctx, ".credit"}, 32'(credit_out),    32'(m_credit));
    check_eq({ctx, ".ovf"},    32'(overflow_err),  32'(m_ovf));
    check_eq({ctx, ".unf"},    32'(underflow_err), 32'(m_unf));
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, check after the edge.
  task automatic step(input string ctx, input bit v, input logic [DW-1:0] d, input bit r);
    bit rd_ok;
    bit wr_ok;
    validin = v;
    datain  = d;
    rd_en   = r;
    rd_ok = r && (m_q.size() > 0);
    wr_ok = v && ((m_q.size() < DEPTH) || rd_ok);
    if (v && (m_q.size() == DEPTH) && !r) m_ovf = 1'b1;
    if (r && (m_q.size() == 0)) m_unf = 1'b1;
    if (rd_ok) void'(m_q.pop_front());
    if (wr_ok) m_q.push_back(d);
    m_credit = rd_ok;
    @(posedge clk);
    #1;
    if (credit_out) n_cred++;
    compare_all(ctx);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_credit = 1'b0;
  endtask

  task automatic apply_reset(input string ctx);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all(ctx);
    validin = 1'b0;
    rd_en   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pv;
    int pr;
    n_checks = 0;
    n_errors = 0;
    n_cred   = 0;
    rst      = 1'b0;
    validin  = 1'b0;
    rd_en    = 1'b0;
    datain   = '0;
    model_reset();

    apply_reset("reset");

    for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'hA1 + 32'(i), 1'b0);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_head", dataout, 32'hA1);
    n_cred = 0;
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 32'h0, 1'b1);
    check_eq("drain_credits", 32'(n_cred), 32'd4);
    step("drain_idle", 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++) step("refill", 1'b1, 32'hD0 + 32'(i), 1'b0);
    step("full_rw", 1'b1, 32'hB0, 1'b1);
    step("full_ovf", 1'b1, 32'hEE, 1'b0);
    for (int i = 0; i < 5; i++) step("drain2", 1'b0, 32'h0, 1'b1);

    step("empty_rw", 1'b1, 32'hC5, 1'b1);
    step("empty_rw_next", 1'b0, 32'h0, 1'b0);
    check_eq("empty_rw_head", dataout, 32'hC5);

    apply_reset("reset2");
    n_cred = 0;
    step("wrap_w", 1'b1, 32'h01, 1'b0);
    step("wrap_w", 1'b1, 32'h02, 1'b0);
    for (int i = 3; i <= 10; i++) step("wrap_rw", 1'b1, 32'(i), 1'b1);
    step("wrap_r", 1'b0, 32'h0, 1'b1);
    step("wrap_r", 1'b0, 32'h0, 1'b1);
    step("wrap_idle", 1'b0, 32'h0, 1'b0);
    check_eq("wrap_credits", 32'(n_cred), 32'd10);

    step("mid_w", 1'b1, 32'h55, 1'b0);
    step("mid_w", 1'b1, 32'h66, 1'b0);
    step("mid_rw", 1'b1, 32'h77, 1'b1);
    apply_reset("mid_reset");

    for (int blk = 0; blk < 4; blk++) begin
      case (blk)
        0:       begin pv = 70; pr = 30; end
        1:       begin pv = 30; pr = 70; end
        2:       begin pv = 50; pr = 50; end
        default: begin pv = 90; pr = 90; end
      endcase
      for (int i = 0; i < 100; i++) begin
        step("rand", ($urandom_range(0, 99) < pv), $urandom(), ($urandom_range(0, 99) < pr));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_router_input_fifo
